cim_mem_req_arbiter: RTL and testbench

//  Requester-side front end of a CiM memory port (int_res or params). Takes per-source valid/ready requests from
//  BUS_FSM, LOGIC_FSM, MAC, LAYERNORM, DATA_FILL_FSM, DENSE_BROADCAST_SAVE_FSM and a spare slot. Grants at most one
//  per cycle and drives the MemAccessSignals fields as registered outputs, so the memory's one-request assertion

---
 rtl/cim_mem_req_arbiter.sv | 140 ++++++++++++++
 tb/tb_cim_mem_req_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// cim_mem_req_arbiter
//
// Requester-side front end of one CiM memory port (int_res or params).
// Up to NUM_SRC sources raise valid/ready requests. At most one is granted per
// cycle, and its request is presented to the memory through registered one-hot
// read/write vectors plus per-slot address/data tables. Only one memory request
// is therefore ever asserted at a time. Read data comes back two cycles after
// the grant, together with a one-hot response valid for the source that read.
//
// Arbitration is fixed-priority (index 0 highest). A source that has waited
// STARVE_LIMIT cycles is promoted ahead of the fixed order.
//
// Ports
//   clk              clock
//   rst_n            synchronous active-low reset
//   req_valid_i      per-source request pending
//   req_write_i      per-source 1=write, 0=read (qualified by req_valid_i)
//   req_addr_i       per-source address, NUM_SRC*ADDR_W
//   req_wdata_i      per-source write data, NUM_SRC*DATA_W
//   req_ready_o      one-hot grant (combinational); consumed on valid&ready
//   rsp_valid_o      one-hot read-data valid for the source that read
//   rsp_data_o       read data, meaningful only with rsp_valid_o
//   read_req_src_o   registered one-hot read request to memory
//   write_req_src_o  registered one-hot write request to memory
//   addr_table_o     registered; only the granted slot is non-zero
//   write_data_o     registered; only the granted slot is non-zero
//   mem_read_data_i  memory Q, valid the cycle after the read request
// -----------------------------------------------------------------------------
module cim_mem_req_arbiter #(
    parameter int NUM_SRC      = 7,
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        req_valid_i,
    input  logic [NUM_SRC-1:0]        req_write_i,
    input  logic [NUM_SRC*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_SRC*DATA_W-1:0] req_wdata_i,
    output logic [NUM_SRC-1:0]        req_ready_o,
    output logic [NUM_SRC-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_data_o,
    output logic [NUM_SRC-1:0]        read_req_src_o,
    output logic [NUM_SRC-1:0]        write_req_src_o,
    output logic [NUM_SRC*ADDR_W-1:0] addr_table_o,
    output logic [NUM_SRC*DATA_W-1:0] write_data_o,
    input  logic [DATA_W-1:0]         mem_read_data_i
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]          wait_cnt_q [NUM_SRC];
    logic [CNT_W-1:0]          wait_cnt_d [NUM_SRC];
    logic [NUM_SRC-1:0]        starved;
    logic [NUM_SRC-1:0]        grant;

    logic [NUM_SRC-1:0]        read_req_src_q,  read_req_src_d;
    logic [NUM_SRC-1:0]        write_req_src_q, write_req_src_d;
    logic [NUM_SRC*ADDR_W-1:0] addr_table_q,    addr_table_d;
    logic [NUM_SRC*DATA_W-1:0] write_data_q,    write_data_d;
    // Tag stage: the one-hot read vector presented to memory, delayed one
    // cycle so it lines up with Q.
    logic [NUM_SRC-1:0]        rsp_valid_q;

    // Grant selection. x & (~x + 1) isolates the lowest set bit, i.e. the
    // lowest-index candidate. Nothing is granted while reset is held so that
    // req_ready_o reads 0 during reset.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        starved = '0;
        grant   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            starved[i] = req_valid_i[i] && (wait_cnt_q[i] == CNT_MAX);
        end
        if (rst_n) begin
            if (|starved) grant = starved & (~starved + 1'b1);
            else          grant = req_valid_i & (~req_valid_i + 1'b1);
        end
    end

    // Next state: wait counters, memory request vectors and slot tables.
    always_comb begin
        read_req_src_d  = grant & ~req_write_i;
        write_req_src_d = grant &  req_write_i;
        addr_table_d    = '0;
        write_data_d    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            wait_cnt_d[i] = '0;
            if (req_valid_i[i] && !grant[i]) begin
                wait_cnt_d[i] = (wait_cnt_q[i] == CNT_MAX) ? CNT_MAX
                                                          : wait_cnt_q[i] + CNT_W'(1);
            end
            if (grant[i]) begin
                addr_table_d[i*ADDR_W +: ADDR_W] = req_addr_i[i*ADDR_W +: ADDR_W];
                write_data_d[i*DATA_W +: DATA_W] = req_wdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            // NOTE: the counter array is small and is cleared in full on reset;
            // a stale count would otherwise promote a source spuriously.
            for (int i = 0; i < NUM_SRC; i++) wait_cnt_q[i] <= '0;
            read_req_src_q  <= '0;
            write_req_src_q <= '0;
            addr_table_q    <= '0;
            write_data_q    <= '0;
            rsp_valid_q     <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) wait_cnt_q[i] <= wait_cnt_d[i];
            read_req_src_q  <= read_req_src_d;
            write_req_src_q <= write_req_src_d;
            addr_table_q    <= addr_table_d;
            write_data_q    <= write_data_d;
            rsp_valid_q     <= read_req_src_q;
        end
    end

    assign req_ready_o     = grant;
    assign read_req_src_o  = read_req_src_q;
    assign write_req_src_o = write_req_src_q;
    assign addr_table_o    = addr_table_q;
    assign write_data_o    = write_data_q;
    assign rsp_valid_o     = rsp_valid_q;
    // Q is forwarded only while a response is due, so the bus is 0 otherwise.
    assign rsp_data_o      = (|rsp_valid_q) ? mem_read_data_i : '0;

`ifndef SYNTHESIS
    a_one_mem_req: assert property (@(posedge clk)
        $countones({read_req_src_q, write_req_src_q}) <= 1);
`endif

endmodule

// File: tb/tb_cim_mem_req_arbiter.sv
module tb_cim_mem_req_arbiter;

    localparam int NS = 7;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int LIM = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NS-1:0]    req_valid = '0;
    logic [NS-1:0]    req_write = '0;
    logic [NS*AW-1:0] req_addr = '0;
    logic [NS*DW-1:0] req_wdata = '0;
    logic [NS-1:0]    req_ready;
    logic [NS-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic [NS-1:0]    read_req_src;
    logic [NS-1:0]    write_req_src;
    logic [NS*AW-1:0] addr_table;
    logic [NS*DW-1:0] write_data;
    logic [DW-1:0]    mem_q = '0;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem     [1024];
    logic [DW-1:0] ref_mem [1024];

    cim_mem_req_arbiter #(.NUM_SRC(NS), .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid_i     (req_valid),
        .req_write_i     (req_write),
        .req_addr_i      (req_addr),
        .req_wdata_i     (req_wdata),
        .req_ready_o     (req_ready),
        .rsp_valid_o     (rsp_valid),
        .rsp_data_o      (rsp_data),
        .read_req_src_o  (read_req_src),
        .write_req_src_o (write_req_src),
        .addr_table_o    (addr_table),
        .write_data_o    (write_data),
        .mem_read_data_i (mem_q)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory: request seen in one cycle, Q the next.
    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (write_req_src[i]) mem[addr_table[i*AW +: AW]] <= write_data[i*DW +: DW];
            if (read_req_src[i])  mem_q <= mem[addr_table[i*AW +: AW]];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input bit v, input bit w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]        = v;
        req_write[i]        = w;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NS; i++) set_src(i, 1'b1, 1'b0, AW'(i + 5), '0);
        tick();
        tick();
        @(negedge clk);
        total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        total++; if (rsp_data !== '0) begin bad++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        total++; if (read_req_src !== '0) begin bad++; $display("FAIL reset_rd: got %b want 0", read_req_src); end
        total++; if (write_req_src !== '0) begin bad++; $display("FAIL reset_wr: got %b want 0", write_req_src); end
        total++; if (addr_table !== '0) begin bad++; $display("FAIL reset_addr: got %h want 0", addr_table); end
        total++; if (write_data !== '0) begin bad++; $display("FAIL reset_wdata: got %h want 0", write_data); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 7'b0000001) begin bad++; $display("FAIL reset_first_grant: got %b want 0000001", req_ready); end
        tick();
        idle(3);
    endtask

    task automatic test_single_read();
        logic [NS*AW-1:0] ea;
        set_src(3, 1'b1, 1'b0, 10'h123, '0);
        @(negedge clk);
        total++; if (req_ready !== 7'b0001000) begin bad++; $display("FAIL single_ready: got %b want 0001000", req_ready); end
        tick();
        req_valid = '0;
        @(negedge clk);
        ea = '0; ea[3*AW +: AW] = 10'h123;
        total++; if (read_req_src !== 7'b0001000) begin bad++; $display("FAIL single_rd: got %b want 0001000", read_req_src); end
        total++; if (addr_table !== ea) begin bad++; $display("FAIL single_addr: got %h want %h", addr_table, ea); end
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL single_rsp_early: got %b want 0", rsp_valid); end
        tick();
        @(negedge clk);
        total++; if (rsp_valid !== 7'b0001000) begin bad++; $display("FAIL single_rsp_valid: got %b want 0001000", rsp_valid); end
        total++; if (rsp_data !== ref_mem[10'h123]) begin bad++; $display("FAIL single_rsp_data: got %h want %h", rsp_data, ref_mem[10'h123]); end
        tick();
        @(negedge clk);
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL single_rsp_pulse: got %b want 0", rsp_valid); end
        tick();
        idle(2);
    endtask

    task automatic test_contention();
        int first5 = -1;
        logic [NS-1:0] exp_g;
        set_src(0, 1'b1, 1'b0, 10'h100, '0);
        set_src(2, 1'b1, 1'b0, 10'h102, '0);
        set_src(5, 1'b1, 1'b0, 10'h105, '0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c < 10) begin
                exp_g = (c < LIM) ? 7'b0000001 : (c == LIM) ? 7'b0000100 : 7'b0100000;
                total++; if (req_ready !== exp_g) begin bad++; $display("FAIL contention_grant c=%0d: got %b want %b", c, req_ready, exp_g); end
            end
            total++; if ($countones({read_req_src, write_req_src}) > 1) begin bad++; $display("FAIL contention_onehot c=%0d: rd=%b wr=%b want at most one", c, read_req_src, write_req_src); end
            if (req_ready[5] && first5 < 0) first5 = c;
            tick();
        end
        total++; if (first5 < 0 || first5 > 2*LIM + 2) begin bad++; $display("FAIL contention_src5: first grant cycle %0d want 0..%0d", first5, 2*LIM + 2); end
        idle(3);
    endtask

    task automatic test_write_then_read();
        logic [NS*AW-1:0] ea;
        logic [NS*DW-1:0] ed;
        set_src(1, 1'b1, 1'b1, 10'h040, 16'hBEEF);
        @(negedge clk);
        total++; if (req_ready !== 7'b0000010) begin bad++; $display("FAIL wtr_wgrant: got %b want 0000010", req_ready); end
        ref_mem[10'h040] = 16'hBEEF;
        tick();
        req_valid = '0;
        set_src(4, 1'b1, 1'b0, 10'h040, '0);
        @(negedge clk);
        ea = '0; ea[1*AW +: AW] = 10'h040;
        ed = '0; ed[1*DW +: DW] = 16'hBEEF;
        total++; if (write_req_src !== 7'b0000010) begin bad++; $display("FAIL wtr_wr: got %b want 0000010", write_req_src); end
        total++; if (addr_table !== ea) begin bad++; $display("FAIL wtr_addr: got %h want %h", addr_table, ea); end
        total++; if (write_data !== ed) begin bad++; $display("FAIL wtr_wdata: got %h want %h", write_data, ed); end
        total++; if (req_ready !== 7'b0010000) begin bad++; $display("FAIL wtr_rgrant: got %b want 0010000", req_ready); end
        tick();
        req_valid = '0;
        @(negedge clk);
        total++; if (read_req_src !== 7'b0010000) begin bad++; $display("FAIL wtr_rd: got %b want 0010000", read_req_src); end
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL wtr_no_wrsp: got %b want 0", rsp_valid); end
        tick();
        @(negedge clk);
        total++; if (rsp_valid !== 7'b0010000) begin bad++; $display("FAIL wtr_rsp_valid: got %b want 0010000", rsp_valid); end
        total++; if (rsp_data !== 16'hBEEF) begin bad++; $display("FAIL wtr_rsp_data: got %h want beef", rsp_data); end
        tick();
        idle(2);
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 8; c++) begin
            if (c < 4) set_src(6, 1'b1, 1'b0, AW'(c), '0);
            else       req_valid = '0;
            @(negedge clk);
            if (c < 4) begin
                total++; if (req_ready !== 7'b1000000) begin bad++; $display("FAIL b2b_grant c=%0d: got %b want 1000000", c, req_ready); end
            end
            if (c >= 2 && c < 6) begin
                total++; if (rsp_valid !== 7'b1000000) begin bad++; $display("FAIL b2b_rsp_valid c=%0d: got %b want 1000000", c, rsp_valid); end
                total++; if (rsp_data !== ref_mem[c-2]) begin bad++; $display("FAIL b2b_rsp_data c=%0d: got %h want %h", c, rsp_data, ref_mem[c-2]); end
            end else begin
                total++; if (rsp_valid !== '0) begin bad++; $display("FAIL b2b_rsp_idle c=%0d: got %b want 0", c, rsp_valid); end
            end
            tick();
        end
        idle(2);
    endtask

    task automatic test_reset_midflight();
        set_src(2, 1'b1, 1'b0, 10'h010, '0);
        @(negedge clk);
        total++; if (req_ready !== 7'b0000100) begin bad++; $display("FAIL mid_grant: got %b want 0000100", req_ready); end
        tick();
        req_valid = '0;
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL mid_rsp_n2: got %b want 0", rsp_valid); end
        total++; if (read_req_src !== '0) begin bad++; $display("FAIL mid_rd: got %b want 0", read_req_src); end
        total++; if (addr_table !== '0) begin bad++; $display("FAIL mid_addr: got %h want 0", addr_table); end
        tick();
        @(negedge clk);
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL mid_rsp_n3: got %b want 0", rsp_valid); end
        tick();
        rst_n = 1'b1;
        idle(2);
    endtask

    // Reference model: each source holds at most one pending request; the
    // winner is the first long-waiting source, else the first pending one.
    task automatic test_random();
        bit            m_v [NS];
        bit            m_w [NS];
        logic [AW-1:0] m_a [NS];
        logic [DW-1:0] m_d [NS];
        int            m_wait [NS];
        int            g;
        logic [NS-1:0]    eg;
        logic [NS-1:0]    s1_rd = '0, s1_wr = '0, s1_rv = '0, s2_rv = '0;
        logic [NS*AW-1:0] s1_a = '0;
        logic [NS*DW-1:0] s1_d = '0;
        logic [DW-1:0]    s1_rdata = '0, s2_rdata = '0;
        for (int i = 0; i < NS; i++) begin m_v[i] = 0; m_wait[i] = 0; end
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int i = 0; i < NS; i++) begin
                if (m_v[i]) begin
                    if ($urandom_range(0, 15) == 0) m_v[i] = 0;
                end else if ($urandom_range(0, 1) == 1) begin
                    m_v[i] = 1;
                    m_w[i] = ($urandom_range(0, 2) == 0);
                    m_a[i] = AW'($urandom_range(0, 15));
                    m_d[i] = DW'($urandom);
                end
                set_src(i, m_v[i], m_w[i], m_a[i], m_d[i]);
            end
            g = -1;
            for (int i = 0; i < NS; i++) if (g < 0 && m_v[i] && m_wait[i] >= LIM) g = i;
            if (g < 0) for (int i = 0; i < NS; i++) if (g < 0 && m_v[i]) g = i;
            eg = (g >= 0) ? (NS'(1) << g) : '0;
            @(negedge clk);
            total++; if (req_ready !== eg) begin bad++; $display("FAIL rand_grant cyc=%0d: got %b want %b", cyc, req_ready, eg); end
            total++; if (read_req_src !== s1_rd) begin bad++; $display("FAIL rand_rd cyc=%0d: got %b want %b", cyc, read_req_src, s1_rd); end
            total++; if (write_req_src !== s1_wr) begin bad++; $display("FAIL rand_wr cyc=%0d: got %b want %b", cyc, write_req_src, s1_wr); end
            total++; if (addr_table !== s1_a) begin bad++; $display("FAIL rand_addr cyc=%0d: got %h want %h", cyc, addr_table, s1_a); end
            total++; if (write_data !== s1_d) begin bad++; $display("FAIL rand_wdata cyc=%0d: got %h want %h", cyc, write_data, s1_d); end
            total++; if (rsp_valid !== s2_rv) begin bad++; $display("FAIL rand_rsp_valid cyc=%0d: got %b want %b", cyc, rsp_valid, s2_rv); end
            if (s2_rv != '0) begin
                total++; if (rsp_data !== s2_rdata) begin bad++; $display("FAIL rand_rsp_data cyc=%0d: got %h want %h", cyc, rsp_data, s2_rdata); end
            end
            s2_rv = s1_rv; s2_rdata = s1_rdata;
            s1_rd = '0; s1_wr = '0; s1_rv = '0; s1_a = '0; s1_d = '0;
            if (g >= 0) begin
                s1_a[g*AW +: AW] = m_a[g];
                s1_d[g*DW +: DW] = m_d[g];
                if (m_w[g]) begin
                    s1_wr = eg;
                    ref_mem[m_a[g]] = m_d[g];
                end else begin
                    s1_rd = eg;
                    s1_rv = eg;
                    s1_rdata = ref_mem[m_a[g]];
                end
            end
            for (int i = 0; i < NS; i++) begin
                if (m_v[i] && i != g) m_wait[i] = (m_wait[i] + 1 > LIM) ? LIM : m_wait[i] + 1;
                else                  m_wait[i] = 0;
            end
            if (g >= 0) m_v[g] = 0;
            tick();
        end
        idle(3);
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) begin
            mem[a]     = DW'(a * 37) ^ 16'hA5C3;
            ref_mem[a] = DW'(a * 37) ^ 16'hA5C3;
        end
        #1;
        test_reset();
        test_single_read();
        test_contention();
        test_write_then_read();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
